// File: rtl/seq_pkg.sv
// Shared opcodes, register-control codes, ULA selects and FSM state encoding
// for the multi-cycle sequencer.
package seq_pkg;

  // Opcodes as fetched from program memory
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LDX    = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [3:0] OP_MVZ    = 4'h4;
  localparam logic [3:0] OP_CLRY   = 4'h5;
  localparam logic [3:0] OP_SHRY   = 4'h6;
  localparam logic [3:0] OP_LDADD  = 4'h7;
  localparam logic [3:0] OP_ADDMV  = 4'h8;
  localparam logic [3:0] OP_CLRALL = 4'h9;
  localparam logic [3:0] OP_ILL_LO = 4'hA;
  localparam logic [3:0] OP_ILL_HI = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // X/Y/Z register controls
  localparam logic [1:0] RC_HOLD  = 2'b00;
  localparam logic [1:0] RC_LOAD  = 2'b01;
  localparam logic [1:0] RC_CLEAR = 2'b10;
  localparam logic [1:0] RC_SHR   = 2'b11;

  // ULA function select
  localparam logic ULA_ADD = 1'b0;  // X+Y
  localparam logic ULA_SUB = 1'b1;  // Y-X

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_EXEC, ST_EXEC2, ST_ADV, ST_HALTED
  } state_t;

endpackage

// File: rtl/seq_control_if.sv
// Sequencer bus: run/step/opcode in, datapath controls and status out.
interface seq_control_if #(parameter int ICNT_W = 8) ();
  logic              run;
  logic              step;
  logic [3:0]        funcao;
  logic [1:0]        tx;
  logic [1:0]        ty;
  logic [1:0]        tz;
  logic              tula;
  logic              pc_inc;
  logic              busy;
  logic              halted;
  logic              illegal;
  logic [ICNT_W-1:0] icount;

  modport master (output run, step, funcao,
                  input  tx, ty, tz, tula, pc_inc, busy, halted, illegal, icount);
  modport slave  (input  run, step, funcao,
                  output tx, ty, tz, tula, pc_inc, busy, halted, illegal, icount);
endinterface

// File: rtl/seq_decode.sv
// Combinational opcode decoder: register/ULA controls for one execute phase
// (phase 0 = EXEC, phase 1 = EXEC2) plus opcode class flags.
module seq_decode import seq_pkg::*; #(
  parameter logic [3:0] HALT_OP = OP_HALT
) (
  input  logic [3:0] ir,
  input  logic       phase,
  output logic [1:0] tx,
  output logic [1:0] ty,
  output logic [1:0] tz,
  output logic       tula,
  output logic       is_macro,
  output logic       is_halt,
  output logic       is_illegal
);

  assign is_halt    = (ir == HALT_OP);
  assign is_illegal = (ir >= OP_ILL_LO) && (ir <= OP_ILL_HI) && !is_halt;

  // Opcode table; tula only leaves ULA_ADD for SUB, so it is 0 whenever ty isn't LOAD
  always_comb begin
    tx       = RC_HOLD;
    ty       = RC_HOLD;
    tz       = RC_HOLD;
    tula     = ULA_ADD;
    is_macro = 1'b0;
    if (!is_halt) begin
      case (ir)
        OP_LDX:    tx = RC_LOAD;
        OP_ADD:    ty = RC_LOAD;
        OP_SUB:    begin ty = RC_LOAD; tula = ULA_SUB; end
        OP_MVZ:    tz = RC_LOAD;
        OP_CLRY:   ty = RC_CLEAR;
        OP_SHRY:   ty = RC_SHR;
        OP_LDADD:  begin
          is_macro = 1'b1;
          if (!phase) tx = RC_LOAD;
          else        ty = RC_LOAD;
        end
        OP_ADDMV:  begin
          is_macro = 1'b1;
          if (!phase) ty = RC_LOAD;
          else        tz = RC_LOAD;
        end
        OP_CLRALL: begin tx = RC_CLEAR; ty = RC_CLEAR; tz = RC_CLEAR; end
        default:   ;  // NOP and illegal opcodes hold everything
      endcase
    end
  end

endmodule

// File: rtl/seq_control.sv
// Multi-cycle sequencer: IDLE -> FETCH -> EXEC [-> EXEC2] -> ADV, with
// free-run, single-step and a terminal HALTED state. Outputs are Moore,
// decoded from the state and instruction registers only.
module seq_control import seq_pkg::*; #(
  parameter int         ICNT_W  = 8,
  parameter logic [3:0] HALT_OP = OP_HALT
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_control_if.slave  bus
);

  state_t            state;
  logic [3:0]        ir;
  logic [ICNT_W-1:0] icountQ;
  logic              illegalQ;

  logic [1:0] decTx, decTy, decTz;
  logic       decTula, decMacro, decHalt, decIllegal;
  logic       phase2;

  logic [1:0] txO, tyO, tzO;
  logic       tulaO, pcIncO, busyO, haltedO;

  assign phase2 = (state == ST_EXEC2);

  seq_decode #(.HALT_OP(HALT_OP)) uDec (
    .ir         (ir),
    .phase      (phase2),
    .tx         (decTx),
    .ty         (decTy),
    .tz         (decTz),
    .tula       (decTula),
    .is_macro   (decMacro),
    .is_halt    (decHalt),
    .is_illegal (decIllegal)
  );

  // Sequencer FSM plus instruction, retired-count and sticky-illegal registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ir       <= '0;
      icountQ  <= '0;
      illegalQ <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:   if (bus.run || bus.step) state <= ST_FETCH;
        ST_FETCH:  begin
          ir    <= bus.funcao;
          state <= ST_EXEC;
        end
        ST_EXEC:   begin
          if (decIllegal) illegalQ <= 1'b1;
          if (decHalt)       state <= ST_HALTED;
          else if (decMacro) state <= ST_EXEC2;
          else               state <= ST_ADV;
        end
        ST_EXEC2:  state <= ST_ADV;
        ST_ADV:    begin
          icountQ <= icountQ + ICNT_W'(1);
          state   <= bus.run ? ST_FETCH : ST_IDLE;
        end
        ST_HALTED: state <= ST_HALTED;  // only reset leaves
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Moore output decode: controls only in execute phases, pulse/status by state
  always_comb begin
    txO     = RC_HOLD;
    tyO     = RC_HOLD;
    tzO     = RC_HOLD;
    tulaO   = ULA_ADD;
    pcIncO  = 1'b0;
    busyO   = 1'b0;
    haltedO = 1'b0;
    case (state)
      ST_FETCH:          busyO = 1'b1;
      ST_EXEC, ST_EXEC2: begin
        busyO = 1'b1;
        txO   = decTx;
        tyO   = decTy;
        tzO   = decTz;
        tulaO = decTula;
      end
      ST_ADV:            begin busyO = 1'b1; pcIncO = 1'b1; end
      ST_HALTED:         haltedO = 1'b1;
      default:           ;
    endcase
  end

  assign bus.tx      = txO;
  assign bus.ty      = tyO;
  assign bus.tz      = tzO;
  assign bus.tula    = tulaO;
  assign bus.pc_inc  = pcIncO;
  assign bus.busy    = busyO;
  assign bus.halted  = haltedO;
  // illegal is visible during the EXEC that decodes it, then held until reset
  assign bus.illegal = illegalQ | ((state == ST_EXEC) & decIllegal);
  assign bus.icount  = icountQ;

endmodule

// File: tb/tb_seq_control.sv
// Bench for seq_control: directed program table, hand-written corner
// sequences, then randomized run/step/opcode traffic against an
// instruction-schedule reference model.
module tb_seq_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_control_if #(.ICNT_W(8)) sif ();

  seq_control #(.ICNT_W(8), .HALT_OP(4'hF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  int vecs = 0;
  int errs = 0;

  // Output word: [18:12] {tx,ty,tz,tula} [11] pc_inc [10] busy [9] halted [8] illegal [7:0] icount
  function automatic logic [18:0] outs();
    return {sif.tx, sif.ty, sif.tz, sif.tula, sif.pc_inc, sif.busy,
            sif.halted, sif.illegal, sif.icount};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input bit r, input bit s, input logic [3:0] f);
    sif.run = r; sif.step = s; sif.funcao = f;
  endtask

  // One cycle: sample at negedge, then move to just after the next rising edge
  task automatic cyc(output logic [18:0] o);
    @(negedge clk);
    o = outs();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    drv(0, 0, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed program table ----------------
  typedef struct {
    bit         run;
    logic [3:0] fn;
    logic [6:0] ctl;   // {tx,ty,tz,tula}
    bit         pc;
    bit         busy;
    logic [7:0] cnt;
  } vec_t;

  function automatic vec_t mkv(bit r, logic [3:0] f, logic [6:0] c, bit p, bit b, logic [7:0] n);
    vec_t v;
    v.run = r; v.fn = f; v.ctl = c; v.pc = p; v.busy = b; v.cnt = n;
    return v;
  endfunction

  vec_t tab [20];

  // ---------------- reference model ----------------
  // Each instruction is expanded into its list of cycles (fetch, one or two
  // execute phases, advance); the head of the list is the current cycle.
  localparam int K_FETCH = 0, K_EXEC = 1, K_ADV = 2;
  typedef struct {
    int         kind;
    logic [3:0] op;
    logic [6:0] ctl;
    bit         ill;
  } slot_t;

  slot_t      sched [$];
  bit         mHalt, mIll;
  logic [7:0] mCnt;
  logic [6:0] p1Tab [16];
  logic [6:0] p2Tab [16];  // nonzero only for two-phase instructions

  function automatic slot_t mkSlot(int k, logic [3:0] op, logic [6:0] c, bit ill);
    slot_t s;
    s.kind = k; s.op = op; s.ctl = c; s.ill = ill;
    return s;
  endfunction

  task automatic mReset();
    sched.delete();
    mHalt = 0; mIll = 0; mCnt = 8'd0;
  endtask

  function automatic logic [18:0] mExp();
    slot_t f;
    if (mHalt)             return {7'd0, 1'b0, 1'b0, 1'b1, mIll, mCnt};
    if (sched.size() == 0) return {7'd0, 1'b0, 1'b0, 1'b0, mIll, mCnt};
    f = sched[0];
    return {(f.kind == K_EXEC) ? f.ctl : 7'd0, (f.kind == K_ADV), 1'b1, 1'b0,
            mIll | f.ill, mCnt};
  endfunction

  task automatic mAdvance();
    slot_t f;
    logic [3:0] op;
    if (mHalt) return;
    if (sched.size() == 0) begin
      if (sif.run || sif.step) sched.push_back(mkSlot(K_FETCH, 4'h0, 7'd0, 0));
      return;
    end
    f = sched.pop_front();
    case (f.kind)
      K_FETCH: begin
        op = sif.funcao;
        sched.push_back(mkSlot(K_EXEC, op, p1Tab[op], (op >= 4'hA && op <= 4'hE)));
        if (op != 4'hF) begin
          if (p2Tab[op] != 7'd0) sched.push_back(mkSlot(K_EXEC, op, p2Tab[op], 0));
          sched.push_back(mkSlot(K_ADV, op, 7'd0, 0));
        end
      end
      K_EXEC: begin
        mIll = mIll | f.ill;
        if (f.op == 4'hF) mHalt = 1;
      end
      default: begin
        mCnt = mCnt + 8'd1;
        if (sif.run) sched.push_back(mkSlot(K_FETCH, 4'h0, 7'd0, 0));
      end
    endcase
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [18:0] o;
    int pcs, bad;
    bit runLvl;
    logic [3:0] fn;

    for (int k = 0; k < 16; k++) begin p1Tab[k] = 7'd0; p2Tab[k] = 7'd0; end
    p1Tab[1] = 7'b01_00_00_0;
    p1Tab[2] = 7'b00_01_00_0;
    p1Tab[3] = 7'b00_01_00_1;
    p1Tab[4] = 7'b00_00_01_0;
    p1Tab[5] = 7'b00_10_00_0;
    p1Tab[6] = 7'b00_11_00_0;
    p1Tab[7] = 7'b01_00_00_0;  p2Tab[7] = 7'b00_01_00_0;
    p1Tab[8] = 7'b00_01_00_0;  p2Tab[8] = 7'b00_00_01_0;
    p1Tab[9] = 7'b10_10_10_0;

    // program 1,2,4 free-running, then macros 7 and 8
    tab[0]  = mkv(1, 4'h1, 7'b00_00_00_0, 0, 0, 0);  // IDLE
    tab[1]  = mkv(1, 4'h1, 7'b00_00_00_0, 0, 1, 0);  // FETCH 1
    tab[2]  = mkv(1, 4'h9, 7'b01_00_00_0, 0, 1, 0);  // EXEC, funcao changed
    tab[3]  = mkv(1, 4'h2, 7'b00_00_00_0, 1, 1, 0);  // ADV
    tab[4]  = mkv(1, 4'h2, 7'b00_00_00_0, 0, 1, 1);  // FETCH 2
    tab[5]  = mkv(1, 4'h2, 7'b00_01_00_0, 0, 1, 1);
    tab[6]  = mkv(1, 4'h4, 7'b00_00_00_0, 1, 1, 1);
    tab[7]  = mkv(1, 4'h4, 7'b00_00_00_0, 0, 1, 2);  // FETCH 4
    tab[8]  = mkv(1, 4'h4, 7'b00_00_01_0, 0, 1, 2);
    tab[9]  = mkv(0, 4'h0, 7'b00_00_00_0, 1, 1, 2);  // ADV, run dropped
    tab[10] = mkv(1, 4'h7, 7'b00_00_00_0, 0, 0, 3);  // IDLE
    tab[11] = mkv(1, 4'h7, 7'b00_00_00_0, 0, 1, 3);  // FETCH 7
    tab[12] = mkv(1, 4'h7, 7'b01_00_00_0, 0, 1, 3);
    tab[13] = mkv(1, 4'h8, 7'b00_01_00_0, 0, 1, 3);
    tab[14] = mkv(1, 4'h8, 7'b00_00_00_0, 1, 1, 3);
    tab[15] = mkv(1, 4'h8, 7'b00_00_00_0, 0, 1, 4);  // FETCH 8
    tab[16] = mkv(1, 4'h3, 7'b00_01_00_0, 0, 1, 4);
    tab[17] = mkv(0, 4'h3, 7'b00_00_01_0, 0, 1, 4);  // run dropped mid-instruction
    tab[18] = mkv(0, 4'h3, 7'b00_00_00_0, 1, 1, 4);
    tab[19] = mkv(0, 4'h3, 7'b00_00_00_0, 0, 0, 5);  // back in IDLE

    // reset state
    drv(0, 0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", outs(), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drv(tab[i].run, 0, tab[i].fn);
      cyc(o);
      chk($sformatf("prog[%0d]", i), o,
          {tab[i].ctl, tab[i].pc, tab[i].busy, 1'b0, 1'b0, tab[i].cnt});
    end

    // async reset during EXEC2 of ADDMV
    drv(1, 0, 4'h8);
    cyc(o); cyc(o);
    cyc(o);
    chk("addmv exec ctl", o[18:12], 7'b00_01_00_0);
    rst_n = 1'b0;  // now in EXEC2
    #1;
    chk("async reset mid-exec2", outs(), 0);
    drv(0, 0, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin cyc(o); if (o != 0) bad++; end
    chk("idle after reset", bad, 0);

    // single step, second step during busy ignored
    doReset();
    pcs = 0;
    drv(0, 1, 4'h3); cyc(o); pcs += o[11];
    drv(0, 0, 4'h3); cyc(o); pcs += o[11];
    drv(0, 1, 4'h5); cyc(o); pcs += o[11];
    chk("step exec ctl", o[18:12], 7'b00_01_00_1);
    drv(0, 0, 4'h5);
    for (int i = 0; i < 5; i++) begin cyc(o); pcs += o[11]; end
    chk("step pc count", pcs, 1);
    chk("step idle busy", o[10], 0);
    chk("step icount", o[7:0], 1);

    // illegal B then HALT
    doReset();
    pcs = 0;
    for (int i = 0; i < 8; i++) begin
      drv(1, 0, (i < 4) ? 4'hB : 4'hF);
      cyc(o);
      pcs += o[11];
      if (i == 2) chk("illegal in exec", o[8], 1);
    end
    chk("halt busy/halted/illegal", o[10:8], 3'b011);
    chk("halt pc count", pcs, 1);
    chk("halt icount", o[7:0], 1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      drv(bit'($urandom % 2), bit'($urandom % 2), 4'($urandom % 16));
      cyc(o);
      if (o[11:8] != 4'b0011 || o[7:0] != 8'd1) bad++;
    end
    chk("halt sticky", bad, 0);
    rst_n = 1'b0;
    #1;
    chk("halt cleared by reset", outs(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 256 NOPs: icount wraps, 256 pc pulses
    doReset();
    pcs = 0;
    for (int i = 0; i <= 768; i++) begin
      drv(bit'(i < 768), 0, 4'h0);
      cyc(o);
      pcs += o[11];
      if (i == 768) chk("icount pre-wrap", o[7:0], 255);
    end
    cyc(o);
    chk("icount wrap", o[7:0], 0);
    chk("nop pc count", pcs, 256);

    // randomized traffic against the model
    doReset();
    mReset();
    runLvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((mHalt && ($urandom % 8 == 0)) || ($urandom % 400 == 0)) begin
        rst_n = 1'b0;
        mReset();
      end else begin
        rst_n = 1'b1;
      end
      if ($urandom % 12 == 0) runLvl = ~runLvl;
      fn = 4'($urandom % 10);
      if ($urandom % 25 == 0) fn = 4'hA + 4'($urandom % 5);
      if ($urandom % 60 == 0) fn = 4'hF;
      drv(runLvl, bit'($urandom % 5 == 0), fn);
      @(negedge clk);
      chk($sformatf("rand[%0d]", i), outs(), mExp());
      @(posedge clk);
      if (rst_n) mAdvance();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seq_control.md
Name: seq_control

Overview:
- Multi-cycle sequencer for the accumulator datapath: PC, program memory, X/Y/Z registers and the two-function ULA.
- Captures the 4-bit opcode (funcao) from program memory and drives the 2-bit register controls tx/ty/tz and the ULA select.
- Advances the PC once per completed instruction.
- Supports free-run, single-step and halt. Replaces the single-cycle Control unit where instructions span several cycles.

Parameters:
ICNT_W, 8, width of retired-instruction counter icount (wraps)
HALT_OP, 4'hF, opcode that halts the sequencer

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = continuous sequencing
step  in  1  1-cycle pulse; executes one instruction when run=0 and in IDLE
funcao  in  4  opcode from program memory at current PC
tx  out  2  X register control
ty  out  2  Y register control
tz  out  2  Z register control
tula  out  1  ULA select: 0 = X+Y, 1 = Y-X
pc_inc  out  1  1-cycle PC advance pulse
busy  out  1  1 in FETCH/EXEC/EXEC2/ADV
halted  out  1  1 in HALTED
illegal  out  1  sticky; set on decode of opcode A-E
icount  out  ICNT_W  retired-instruction count

Behaviour:
- Clock/reset: one clock clk. Reset rst_n is asynchronous, active-low. On reset, including mid-instruction:
  - state = IDLE, ir = 0.
  - tx/ty/tz = HOLD (00), tula = 0, pc_inc = 0, busy = 0, halted = 0, illegal = 0, icount = 0.
- Register control codes: 00 HOLD, 01 LOAD, 10 CLEAR, 11 SHR.
- Outputs are Moore: decoded from state and the ir register only, never directly from funcao.
- States and transitions:
  - IDLE: next = FETCH if run=1, or if run=0 and step=1. Otherwise stay in IDLE.
  - FETCH: ir <= funcao; all controls HOLD. Next = EXEC.
  - EXEC: drive phase-1 controls for ir.
    - ir == HALT_OP: next = HALTED; no pc_inc; icount unchanged.
    - Macro op: next = EXEC2.
    - Otherwise: next = ADV.
  - EXEC2: drive phase-2 controls. Next = ADV.
  - ADV: all controls HOLD; pc_inc = 1; icount += 1 (wraps to 0). Next = FETCH if run=1, else IDLE.
  - HALTED: controls HOLD; halted = 1. Leaves only on reset; run and step are ignored.
- Opcode table (phase 1 / phase 2):
  - 0 NOP: all HOLD.
  - 1 LDX: tx = LOAD.
  - 2 ADD: ty = LOAD, tula = 0.
  - 3 SUB: ty = LOAD, tula = 1.
  - 4 MVZ: tz = LOAD.
  - 5 CLRY: ty = CLEAR.
  - 6 SHRY: ty = SHR.
  - 7 LDADD (macro): tx = LOAD / then ty = LOAD, tula = 0.
  - 8 ADDMV (macro): ty = LOAD, tula = 0 / then tz = LOAD.
  - 9 CLRALL: tx = ty = tz = CLEAR.
  - A-E illegal: execute as NOP (ADV still occurs); illegal set in EXEC and stays set until reset.
  - F HALT.
- Latency, FETCH to ADV inclusive: 3 cycles single-phase, 4 cycles macro. In free-run, back-to-back instructions have no idle cycle.
- tula is 0 whenever ty != LOAD.
- Boundary cases:
  - run deasserted mid-instruction: the instruction completes through ADV, then IDLE.
  - step with run=1, or step outside IDLE: ignored.
  - step and run rising together: treated as run.
  - icount wraps from all-ones to 0 without flag.
  - funcao changes after FETCH: no effect on the current instruction.

Decomposition:
- Package seq_pkg holds:
  - opcode localparams (OP_NOP..OP_HALT);
  - register control codes (RC_HOLD, RC_LOAD, RC_CLEAR, RC_SHR);
  - ULA select codes;
  - state encoding (ST_IDLE, ST_FETCH, ST_EXEC, ST_EXEC2, ST_ADV, ST_HALTED).
- One combinational sub-module, seq_decode: inputs (ir, phase); outputs (tx, ty, tz, tula, is_macro, is_halt, is_illegal).
- The FSM, ir, icount and illegal registers live in seq_control.

Test Plan:
- Reset then run=1, program 1,2,4: tx=01 in cycle 2; ty=01 with tula=0 in cycle 5; tz=01 in cycle 8; pc_inc pulses at cycles 3, 6, 9; icount=3.
- Macro 7 with run=1: EXEC tx=01, EXEC2 ty=01, one pc_inc, 4 cycles total; opcode 8 gives ty=01 then tz=01.
- run=0, single step pulse with funcao=3: exactly one instruction (ty=01, tula=1, one pc_inc), then IDLE with busy=0; a second step during busy is ignored.
- Opcode B then F: illegal=1 and pc_inc for B; F gives halted=1, no pc_inc, icount unchanged; run/step toggling keeps HALTED until rst_n=0.
- rst_n low during EXEC2 of opcode 8: all outputs immediately at reset values with no clock edge; tz never reaches 01.
- 256 NOPs with ICNT_W=8: icount wraps to 0 and pc_inc count equals 256.
